// File: rtl/multi_master_bus.sv
// Shared-bus interconnect: N_MASTER masters onto N_SLAVE address-decoded slaves.
// Latency: request->grant 1 cycle; slave side combinational from owner; read data 1 cycle after select.
// Backpressure: losers hold m_req with m_grant=0; the owner is never preempted while it holds m_req.
//
// Build option: define BUS_RR_ARB_EN for round-robin arbitration; otherwise fixed priority
// (lowest master index wins).
//
// Ports:
//   clk, reset_n        single clock, synchronous active-low reset
//   m_req/m_wr          per-master request (held for the whole burst) and write(1)/read(0)
//   m_addr/m_dout       packed per-master address and write data (master i at [i*W +: W])
//   m_grant             one-hot registered grant
//   m_din               read data broadcast to all masters (0 when no read is returning)
//   s_dout              packed per-slave read data from synchronous RAM slaves
//   s_sel/s_wr          one-hot slave select and write strobe
//   s_addr/s_din        full address and write data to slaves (0 when the bus is idle)
//   decode_err          one-cycle pulse: the previous access hit an unmapped region

module multi_master_bus #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 5,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int REGION_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_MASTER-1:0]          m_req,
    input  logic [N_MASTER-1:0]          m_wr,
    input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTER*DATA_W-1:0]   m_dout,
    output logic [N_MASTER-1:0]          m_grant,
    output logic [DATA_W-1:0]            m_din,
    input  logic [N_SLAVE*DATA_W-1:0]    s_dout,
    output logic [N_SLAVE-1:0]           s_sel,
    output logic                         s_wr,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_din,
    output logic                         decode_err
);

    localparam int OWN_W  = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int SIDX_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam int RIDX_W = ADDR_W - REGION_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [OWN_W-1:0]      r_owner;
    logic [N_MASTER-1:0]   r_grant;
    logic                  r_rd_vld;
    logic [SIDX_W-1:0]     r_rd_idx;
    logic                  r_decode_err;
`ifdef BUS_RR_ARB_EN
    logic [OWN_W-1:0]      r_last_owner;
`endif

    // ------------------------------------------------------------------
    // Owner-side mux: pick the current owner's request fields
    // ------------------------------------------------------------------
    logic                  w_own_req;
    logic                  w_own_wr;
    logic [ADDR_W-1:0]     w_own_addr;
    logic [DATA_W-1:0]     w_own_dout;

    always_comb begin
        w_own_req  = 1'b0;
        w_own_wr   = 1'b0;
        w_own_addr = '0;
        w_own_dout = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (r_owner == OWN_W'(i)) begin
                w_own_req  = m_req[i];
                w_own_wr   = m_wr[i];
                w_own_addr = m_addr[i*ADDR_W +: ADDR_W];
                w_own_dout = m_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    // The slave side is live only while the owner still asserts its request.
    // Gating with reset_n keeps a write from landing at the very edge that
    // resets the bus.
    logic                  w_active;
    logic [RIDX_W-1:0]     w_sidx;
    logic                  w_hit;
    logic                  w_sel_vld;

    assign w_active  = reset_n && (r_state == ST_OWNED) && w_own_req;
    assign w_sidx    = w_own_addr[ADDR_W-1:REGION_W];
    assign w_hit     = (32'(w_sidx) < 32'(N_SLAVE));
    assign w_sel_vld = w_active && w_hit;

    always_comb begin
        s_sel = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            s_sel[k] = w_sel_vld && (32'(w_sidx) == 32'(k));
        end
    end

    // Address and data follow the owner even on an unmapped access; only the
    // select and the write strobe are suppressed there.
    assign s_wr   = w_sel_vld && w_own_wr;
    assign s_addr = w_active ? w_own_addr : '0;
    assign s_din  = w_active ? w_own_dout : '0;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                  w_arb_vld;
    logic [OWN_W-1:0]      w_arb_idx;
    logic [N_MASTER-1:0]   w_arb_oh;

`ifdef BUS_RR_ARB_EN
    // Round-robin: prefer the lowest requester above last_owner, else wrap
    // around to the lowest requester overall.
    logic                  w_hi_vld;
    logic [OWN_W-1:0]      w_hi_idx;

    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        w_hi_vld  = 1'b0;
        w_hi_idx  = '0;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = OWN_W'(i);
                if (OWN_W'(i) > r_last_owner) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = OWN_W'(i);
                end
            end
        end
        if (w_hi_vld) begin
            w_arb_idx = w_hi_idx;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = OWN_W'(i);
            end
        end
    end
`endif

    assign w_arb_oh = N_MASTER'(1) << w_arb_idx;

    // ------------------------------------------------------------------
    // Arbiter FSM and read-return / decode-error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_grant      <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_decode_err <= 1'b0;
`ifdef BUS_RR_ARB_EN
            r_last_owner <= OWN_W'(N_MASTER - 1);
`endif
        end else begin
            // Read return tracks the select cycle; rd_idx is left alone on
            // non-read cycles so a handover never disturbs the last return.
            r_rd_vld     <= w_sel_vld && !w_own_wr;
            if (w_sel_vld && !w_own_wr) begin
                r_rd_idx <= SIDX_W'(w_sidx);
            end
            r_decode_err <= w_active && !w_hit;

            case (r_state)
                ST_IDLE: begin
                    if (w_arb_vld) begin
                        r_state      <= ST_OWNED;
                        r_owner      <= w_arb_idx;
                        r_grant      <= w_arb_oh;
`ifdef BUS_RR_ARB_EN
                        r_last_owner <= w_arb_idx;
`endif
                    end
                end
                ST_OWNED: begin
                    if (!w_own_req) begin
                        // Owner released: hand over directly if anyone waits
                        // (the owner's own request is low, so it cannot win).
                        if (w_arb_vld) begin
                            r_owner      <= w_arb_idx;
                            r_grant      <= w_arb_oh;
`ifdef BUS_RR_ARB_EN
                            r_last_owner <= w_arb_idx;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign m_grant    = r_grant;
    assign decode_err = r_decode_err;

    // ------------------------------------------------------------------
    // Read-data return mux
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     w_rd_dat;

    always_comb begin
        w_rd_dat = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if (r_rd_idx == SIDX_W'(k)) begin
                w_rd_dat = s_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    assign m_din = r_rd_vld ? w_rd_dat : '0;

endmodule
